nv_nvdla_cvif_axi_wr_responder: RTL

//  AXI write-slave endpoint for the CVIF NOC write port (the far end of cvif2noc_axi_aw/w, noc2cvif_axi_b).
//  - Accepts AW and W channels.
//  - Issues each beat as a 512-bit byte-masked write on a simple memory port.
//  - Returns one in-order B response per burst, carrying the burst's awid.
//  - Used as the NOC-side memory/responder for CVIF subsystem sims and FPGA bring-up.

---
 rtl/nv_nvdla_cvif_axi_wr_responder_if.sv | 44 ++++
 rtl/nv_nvdla_cvif_axi_wr_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_cvif_axi_wr_responder_if.sv
// nv_nvdla_cvif_axi_wr_responder_if
//   Bundles the CVIF NOC write-port handshakes (AW, W, B), the 512-bit
//   byte-masked memory write port and the wlast error pulse.
//   Modports:
//     slave  - the responder (accepts AW/W, drives B, memory port, err_wlast)
//     master - the CVIF side / environment driving AW/W and B ready
interface nv_nvdla_cvif_axi_wr_responder_if;
  logic         cvif2noc_axi_aw_awvalid;
  logic         cvif2noc_axi_aw_awready;
  logic [7:0]   cvif2noc_axi_aw_awid;
  logic [3:0]   cvif2noc_axi_aw_awlen;
  logic [63:0]  cvif2noc_axi_aw_awaddr;
  logic         cvif2noc_axi_w_wvalid;
  logic         cvif2noc_axi_w_wready;
  logic [511:0] cvif2noc_axi_w_wdata;
  logic [63:0]  cvif2noc_axi_w_wstrb;
  logic         cvif2noc_axi_w_wlast;
  logic         noc2cvif_axi_b_bvalid;
  logic         noc2cvif_axi_b_bready;
  logic [7:0]   noc2cvif_axi_b_bid;
  logic         mem_wr_en;
  logic [63:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic [63:0]  mem_wr_strb;
  logic         err_wlast;

  modport slave (
    input  cvif2noc_axi_aw_awvalid, cvif2noc_axi_aw_awid, cvif2noc_axi_aw_awlen,
           cvif2noc_axi_aw_awaddr, cvif2noc_axi_w_wvalid, cvif2noc_axi_w_wdata,
           cvif2noc_axi_w_wstrb, cvif2noc_axi_w_wlast, noc2cvif_axi_b_bready,
    output cvif2noc_axi_aw_awready, cvif2noc_axi_w_wready, noc2cvif_axi_b_bvalid,
           noc2cvif_axi_b_bid, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb,
           err_wlast
  );

  modport master (
    output cvif2noc_axi_aw_awvalid, cvif2noc_axi_aw_awid, cvif2noc_axi_aw_awlen,
           cvif2noc_axi_aw_awaddr, cvif2noc_axi_w_wvalid, cvif2noc_axi_w_wdata,
           cvif2noc_axi_w_wstrb, cvif2noc_axi_w_wlast, noc2cvif_axi_b_bready,
    input  cvif2noc_axi_aw_awready, cvif2noc_axi_w_wready, noc2cvif_axi_b_bvalid,
           noc2cvif_axi_b_bid, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb,
           err_wlast
  );
endinterface

// File: rtl/nv_nvdla_cvif_axi_wr_responder.sv
// nv_nvdla_cvif_axi_wr_responder
//   AXI write-slave endpoint for the CVIF NOC write port. Queues AW commands,
//   turns each W beat into a registered 512-bit byte-masked memory write and
//   returns one in-order B response (carrying awid) per completed burst.
//   Ports:
//     nvdla_core_clk   core clock
//     nvdla_core_rstn  async active-low reset
//     bus              slave modport of nv_nvdla_cvif_axi_wr_responder_if
//     stat_burst_cnt   B handshakes seen   (only with CVIF_WR_RSP_STATS_EN)
//     stat_beat_cnt    W handshakes seen   (only with CVIF_WR_RSP_STATS_EN)
//   Optional feature macro: CVIF_WR_RSP_STATS_EN
module nv_nvdla_cvif_axi_wr_responder #(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 8
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  nv_nvdla_cvif_axi_wr_responder_if.slave bus
`ifdef CVIF_WR_RSP_STATS_EN
  ,
  output logic [31:0] stat_burst_cnt,
  output logic [31:0] stat_beat_cnt
`endif
);

  localparam int AW_PW = $clog2(AW_DEPTH);
  localparam int AW_CW = AW_PW + 1;
  localparam int B_PW  = $clog2(B_DEPTH);
  localparam int B_CW  = B_PW + 1;
  localparam logic [AW_CW-1:0] LP_AW_FULL = AW_CW'(AW_DEPTH);
  localparam logic [AW_CW-1:0] LP_AW_ONE  = AW_CW'(1);
  localparam logic [B_CW-1:0]  LP_B_FULL  = B_CW'(B_DEPTH);
  localparam logic [B_CW-1:0]  LP_B_ONE   = B_CW'(1);

  logic [7:0]       r_aw_id   [AW_DEPTH];
  logic [3:0]       r_aw_len  [AW_DEPTH];
  logic [63:0]      r_aw_addr [AW_DEPTH];
  logic [AW_PW-1:0] r_aw_wp, r_aw_rp;
  logic [AW_CW-1:0] r_aw_cnt;
  logic [7:0]       r_b_id [B_DEPTH];
  logic [B_PW-1:0]  r_b_wp, r_b_rp;
  logic [B_CW-1:0]  r_b_cnt;
  logic [3:0]       r_beat_cnt;
  logic             r_rdy_en;
  logic             r_mem_wr_en;
  logic [63:0]      r_mem_wr_addr;
  logic [511:0]     r_mem_wr_data;
  logic [63:0]      r_mem_wr_strb;
  logic             r_err_wlast;

  logic        w_awready, w_aw_push, w_aw_head_vld, w_wready, w_w_hs;
  logic        w_last_beat, w_aw_pop, w_bvalid, w_b_pop;
  logic [3:0]  w_head_len;
  logic [63:0] w_head_addr, w_beat_addr;

  // r_rdy_en keeps awready low while reset is asserted so every output is 0.
  assign w_awready     = r_rdy_en & (r_aw_cnt != LP_AW_FULL);
  assign w_aw_push     = bus.cvif2noc_axi_aw_awvalid & w_awready;
  assign w_aw_head_vld = (r_aw_cnt != '0);
  assign w_wready      = w_aw_head_vld & (r_b_cnt < LP_B_FULL);
  assign w_w_hs        = bus.cvif2noc_axi_w_wvalid & w_wready;
  assign w_head_len    = r_aw_len[r_aw_rp];
  assign w_head_addr   = r_aw_addr[r_aw_rp];
  assign w_last_beat   = (r_beat_cnt == w_head_len);
  assign w_aw_pop      = w_w_hs & w_last_beat;
  assign w_bvalid      = (r_b_cnt != '0);
  assign w_b_pop       = w_bvalid & bus.noc2cvif_axi_b_bready;
  // Beat address: 64B-aligned burst base plus beat index * 64, wrapping mod 2^64.
  assign w_beat_addr   = (w_head_addr & ~64'h3F) + {54'b0, r_beat_cnt, 6'b0};

  assign bus.cvif2noc_axi_aw_awready = w_awready;
  assign bus.cvif2noc_axi_w_wready   = w_wready;
  assign bus.noc2cvif_axi_b_bvalid   = w_bvalid;
  assign bus.noc2cvif_axi_b_bid      = r_b_id[r_b_rp];
  assign bus.mem_wr_en               = r_mem_wr_en;
  assign bus.mem_wr_addr             = r_mem_wr_addr;
  assign bus.mem_wr_data             = r_mem_wr_data;
  assign bus.mem_wr_strb             = r_mem_wr_strb;
  assign bus.err_wlast               = r_err_wlast;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < AW_DEPTH; i++) begin
        r_aw_id[i]   <= '0;
        r_aw_len[i]  <= '0;
        r_aw_addr[i] <= '0;
      end
      r_aw_wp  <= '0;
      r_aw_rp  <= '0;
      r_aw_cnt <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_aw_push) begin
        r_aw_id[r_aw_wp]   <= bus.cvif2noc_axi_aw_awid;
        r_aw_len[r_aw_wp]  <= bus.cvif2noc_axi_aw_awlen;
        r_aw_addr[r_aw_wp] <= bus.cvif2noc_axi_aw_awaddr;
        r_aw_wp            <= r_aw_wp + 1'b1;
      end
      if (w_aw_pop) r_aw_rp <= r_aw_rp + 1'b1;
      case ({w_aw_push, w_aw_pop})
        2'b10:   r_aw_cnt <= r_aw_cnt + LP_AW_ONE;
        2'b01:   r_aw_cnt <= r_aw_cnt - LP_AW_ONE;
        default: r_aw_cnt <= r_aw_cnt;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_beat_cnt    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_mem_wr_strb <= '0;
      r_err_wlast   <= 1'b0;
    end else begin
      r_mem_wr_en <= w_w_hs;
      r_err_wlast <= w_w_hs & (bus.cvif2noc_axi_w_wlast != w_last_beat);
      if (w_w_hs) begin
        r_mem_wr_addr <= w_beat_addr;
        r_mem_wr_data <= bus.cvif2noc_axi_w_wdata;
        r_mem_wr_strb <= bus.cvif2noc_axi_w_wstrb;
        r_beat_cnt    <= w_last_beat ? 4'd0 : r_beat_cnt + 4'd1;
      end
    end
  end

  // The B push is the AW pop: the completing burst's awid enters the queue.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      for (int i = 0; i < B_DEPTH; i++) r_b_id[i] <= '0;
      r_b_wp  <= '0;
      r_b_rp  <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_aw_pop) begin
        r_b_id[r_b_wp] <= r_aw_id[r_aw_rp];
        r_b_wp         <= r_b_wp + 1'b1;
      end
      if (w_b_pop) r_b_rp <= r_b_rp + 1'b1;
      case ({w_aw_pop, w_b_pop})
        2'b10:   r_b_cnt <= r_b_cnt + LP_B_ONE;
        2'b01:   r_b_cnt <= r_b_cnt - LP_B_ONE;
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

`ifdef CVIF_WR_RSP_STATS_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stat_burst_cnt <= '0;
      stat_beat_cnt  <= '0;
    end else begin
      if (w_b_pop) stat_burst_cnt <= stat_burst_cnt + 32'd1;
      if (w_w_hs)  stat_beat_cnt  <= stat_beat_cnt + 32'd1;
    end
  end
`endif

endmodule
